// File: rtl/posit_pkg.sv
// rtl/posit_pkg.sv - shared constants and FSM state type for the posit multiplier
//
// Purpose : Common posit format parameters, the controller watchdog default and
//           the controller state encoding, imported by the posit control blocks.
// Ports   : none (package)

package posit_pkg;

   // Posit format shared with the datapath units (exponent size, regime field width).
   localparam int ES              = 2;
   localparam int K_BITS          = 5;

   // Default watchdog budget per sub-unit phase, in clock cycles.
   localparam int TIMEOUT_DEFAULT = 64;

   // Controller state encoding.
   localparam int         ST_W      = 3;
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_DECODE = 3'd1;
   localparam logic [2:0] ST_EXEC   = 3'd2;
   localparam logic [2:0] ST_NORM   = 3'd3;
   localparam logic [2:0] ST_HOLD   = 3'd4;

   typedef enum logic [ST_W-1:0] {
      S_IDLE   = ST_IDLE,
      S_DECODE = ST_DECODE,
      S_EXEC   = ST_EXEC,
      S_NORM   = ST_NORM,
      S_HOLD   = ST_HOLD
   } state_e;

endpackage

// File: rtl/phase_watchdog.sv
// rtl/phase_watchdog.sv - per-phase cycle watchdog for the posit multiplier controller
//
// Purpose : Counts cycles spent in the current phase; flags expiry on the
//           TIMEOUT-th enabled cycle since the last clear.
// Ports   : clk, rst_n   clock, asynchronous active-low reset
//           clear_i      restart count from zero (phase entry), wins over enable_i
//           enable_i     count this cycle (controller is in a timed phase)
//           expired_o    current enabled cycle is the last one of the budget

module phase_watchdog
   import posit_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int            CW   = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Saturate at LAST so a stalled phase never wraps back to a short count.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i && (cnt_q != LAST)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = enable_i && (cnt_q == LAST);

endmodule

// File: rtl/posit_mul_ctrl.sv
// rtl/posit_mul_ctrl.sv - sequencing controller for the posit multiplier sub-units
//
// Purpose : Steps decoder, exponent adder + mantissa multiplier, and normaliser
//           through IDLE/DECODE/EXEC/NORM/HOLD, routes NaR/zero special cases
//           straight to HOLD, and aborts any phase exceeding TIMEOUT cycles.
// Ports   : clk, rst_n                          clock, asynchronous active-low reset
//           in_valid / in_ready                 operand handshake (ready only in IDLE)
//           dec_start / dec_done, dec_nar/zero  decoder control and class flags
//           exp_start / exp_done / exp_recieved exponent adder control, exp_nar/zero flags
//           mant_start / mant_done / mant_recieved  mantissa multiplier control
//           norm_start / norm_done              normaliser/encoder control
//           out_valid / out_ready               result handshake
//           res_nar, res_zero                   result-class override for encoder mux
//           err                                 sticky timeout flag
//           busy                                controller not idle

module posit_mul_ctrl
   import posit_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in_valid,
   output logic in_ready,
   output logic dec_start,
   input  logic dec_done,
   input  logic dec_nar,
   input  logic dec_zero,
   output logic exp_start,
   input  logic exp_done,
   output logic exp_recieved,
   input  logic exp_nar,
   input  logic exp_zero,
   output logic mant_start,
   input  logic mant_done,
   output logic mant_recieved,
   output logic norm_start,
   input  logic norm_done,
   output logic out_valid,
   input  logic out_ready,
   output logic res_nar,
   output logic res_zero,
   output logic err,
   output logic busy
);

   state_e state_q, state_d;
   logic   exp_seen_q, exp_seen_d;
   logic   mant_seen_q, mant_seen_d;
   logic   exp_nar_q, exp_nar_d;
   logic   exp_zero_q, exp_zero_d;
   logic   res_nar_q, res_nar_d;
   logic   res_zero_q, res_zero_d;
   logic   err_q, err_d;

   logic   wd_clear, wd_enable, wd_expired;
   logic   exp_got, mant_got, x_nar, x_zero;

   assign wd_enable = (state_q == S_DECODE) || (state_q == S_EXEC) || (state_q == S_NORM);

   phase_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear_i   (wd_clear),
      .enable_i  (wd_enable),
      .expired_o (wd_expired)
   );

   // A done level counts if seen now or latched earlier in this EXEC phase.
   assign exp_got  = exp_seen_q  || exp_done;
   assign mant_got = mant_seen_q || mant_done;
   // Exponent flags come from the cycle exp_done was first seen.
   assign x_nar    = exp_seen_q ? exp_nar_q  : exp_nar;
   assign x_zero   = exp_seen_q ? exp_zero_q : exp_zero;

   // Start pulses are issued on the transition cycle (Mealy) so a zero-wait
   // sub-unit answers on the very next cycle, giving the minimum latency.
   always_comb begin
      state_d       = state_q;
      exp_seen_d    = exp_seen_q;
      mant_seen_d   = mant_seen_q;
      exp_nar_d     = exp_nar_q;
      exp_zero_d    = exp_zero_q;
      res_nar_d     = res_nar_q;
      res_zero_d    = res_zero_q;
      err_d         = err_q;
      wd_clear      = 1'b0;
      dec_start     = 1'b0;
      exp_start     = 1'b0;
      mant_start    = 1'b0;
      norm_start    = 1'b0;
      exp_recieved  = 1'b0;
      mant_recieved = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               dec_start = 1'b1;
               wd_clear  = 1'b1;
               state_d   = S_DECODE;
            end
         end

         S_DECODE: begin
            if (dec_done) begin
               wd_clear = 1'b1;
               if (dec_nar) begin
                  res_nar_d = 1'b1;
                  state_d   = S_HOLD;
               end else if (dec_zero) begin
                  res_zero_d = 1'b1;
                  state_d    = S_HOLD;
               end else begin
                  exp_start  = 1'b1;
                  mant_start = 1'b1;
                  state_d    = S_EXEC;
               end
            end else if (wd_expired) begin
               err_d     = 1'b1;
               res_nar_d = 1'b1;
               state_d   = S_HOLD;
            end
         end

         S_EXEC: begin
            if (exp_done && !exp_seen_q) begin
               exp_seen_d = 1'b1;
               exp_nar_d  = exp_nar;
               exp_zero_d = exp_zero;
            end
            if (mant_done) begin
               mant_seen_d = 1'b1;
            end
            if (exp_got && mant_got) begin
               exp_recieved  = 1'b1;
               mant_recieved = 1'b1;
               exp_seen_d    = 1'b0;
               mant_seen_d   = 1'b0;
               wd_clear      = 1'b1;
               if (x_nar) begin
                  res_nar_d = 1'b1;
                  state_d   = S_HOLD;
               end else if (x_zero) begin
                  res_zero_d = 1'b1;
                  state_d    = S_HOLD;
               end else begin
                  norm_start = 1'b1;
                  state_d    = S_NORM;
               end
            end else if (wd_expired) begin
               exp_seen_d  = 1'b0;
               mant_seen_d = 1'b0;
               err_d       = 1'b1;
               res_nar_d   = 1'b1;
               state_d     = S_HOLD;
            end
         end

         S_NORM: begin
            if (norm_done) begin
               wd_clear = 1'b1;
               state_d  = S_HOLD;
            end else if (wd_expired) begin
               err_d     = 1'b1;
               res_nar_d = 1'b1;
               state_d   = S_HOLD;
            end
         end

         S_HOLD: begin
            if (out_ready) begin
               res_nar_d  = 1'b0;
               res_zero_d = 1'b0;
               state_d    = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         exp_seen_q  <= 1'b0;
         mant_seen_q <= 1'b0;
         exp_nar_q   <= 1'b0;
         exp_zero_q  <= 1'b0;
         res_nar_q   <= 1'b0;
         res_zero_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         exp_seen_q  <= exp_seen_d;
         mant_seen_q <= mant_seen_d;
         exp_nar_q   <= exp_nar_d;
         exp_zero_q  <= exp_zero_d;
         res_nar_q   <= res_nar_d;
         res_zero_q  <= res_zero_d;
         err_q       <= err_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign out_valid = (state_q == S_HOLD);
   assign res_nar   = res_nar_q;
   assign res_zero  = res_zero_q;
   assign err       = err_q;

endmodule

// File: tb/tb_posit_mul_ctrl.sv
// tb/tb_posit_mul_ctrl.sv - directed self-checking bench for posit_mul_ctrl

module tb_posit_mul_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n = 1'b0;
   logic in_valid = 1'b0, in_ready;
   logic dec_start, dec_done = 1'b0, dec_nar = 1'b0, dec_zero = 1'b0;
   logic exp_start, exp_done = 1'b0, exp_recieved, exp_nar = 1'b0, exp_zero = 1'b0;
   logic mant_start, mant_done = 1'b0, mant_recieved;
   logic norm_start, norm_done = 1'b0;
   logic out_valid, out_ready = 1'b0;
   logic res_nar, res_zero, err, busy;

   posit_mul_ctrl #(.TIMEOUT(8)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .dec_start     (dec_start),
      .dec_done      (dec_done),
      .dec_nar       (dec_nar),
      .dec_zero      (dec_zero),
      .exp_start     (exp_start),
      .exp_done      (exp_done),
      .exp_recieved  (exp_recieved),
      .exp_nar       (exp_nar),
      .exp_zero      (exp_zero),
      .mant_start    (mant_start),
      .mant_done     (mant_done),
      .mant_recieved (mant_recieved),
      .norm_start    (norm_start),
      .norm_done     (norm_done),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .res_nar       (res_nar),
      .res_zero      (res_zero),
      .err           (err),
      .busy          (busy)
   );

   int checks = 0;
   int failures = 0;
   int n_exp_start = 0, n_norm_start = 0, n_exp_rcv = 0, n_mant_rcv = 0;

   always @(negedge clk) begin
      if (exp_start)     n_exp_start++;
      if (norm_start)    n_norm_start++;
      if (exp_recieved)  n_exp_rcv++;
      if (mant_recieved) n_mant_rcv++;
   end

   // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic release_hold();
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
      end
      checks++;
      if ({busy, out_valid, err, res_nar, res_zero, dec_start, exp_start, mant_start,
           norm_start, exp_recieved, mant_recieved} !== 11'b0) begin
         failures++;
         $display("FAIL reset_outputs got=%b exp=0", {busy, out_valid, err, res_nar, res_zero,
                  dec_start, exp_start, mant_start, norm_start, exp_recieved, mant_recieved});
      end
      cyc();
      rst_n = 1'b1;
   endtask

   task automatic test_normal();
      int e0, m0, n0;
      e0 = n_exp_rcv; m0 = n_mant_rcv; n0 = n_norm_start;
      cyc(); in_valid = 1'b1; #1;
      checks++;
      if ({dec_start, in_ready} !== 2'b11) begin
         failures++; $display("FAIL normal_accept got=%b exp=11", {dec_start, in_ready});
      end
      cyc(); in_valid = 1'b0; dec_done = 1'b1; #1;
      checks++;
      if ({exp_start, mant_start, busy} !== 3'b111) begin
         failures++; $display("FAIL normal_exec_start got=%b exp=111", {exp_start, mant_start, busy});
      end
      cyc(); dec_done = 1'b0;
      cyc(); exp_done = 1'b1;
      cyc();
      cyc(); #1;
      checks++;
      if ({exp_recieved, mant_recieved} !== 2'b00) begin
         failures++; $display("FAIL normal_early_rcv got=%b exp=00", {exp_recieved, mant_recieved});
      end
      cyc(); mant_done = 1'b1; #1;
      checks++;
      if ({exp_recieved, mant_recieved, norm_start} !== 3'b111) begin
         failures++;
         $display("FAIL normal_rcv got=%b exp=111", {exp_recieved, mant_recieved, norm_start});
      end
      cyc(); exp_done = 1'b0; mant_done = 1'b0; #1;
      checks++;
      if ({norm_start, exp_recieved, out_valid} !== 3'b000) begin
         failures++; $display("FAIL normal_norm_wait got=%b exp=000", {norm_start, exp_recieved, out_valid});
      end
      cyc(); norm_done = 1'b1;
      cyc(); norm_done = 1'b0; #1;
      checks++;
      if ({out_valid, res_nar, res_zero, in_ready} !== 4'b1000) begin
         failures++;
         $display("FAIL normal_hold got=%b exp=1000", {out_valid, res_nar, res_zero, in_ready});
      end
      release_hold(); #1;
      checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
         failures++; $display("FAIL normal_idle got=%b exp=10", {in_ready, out_valid});
      end
      checks++;
      if ((n_exp_rcv - e0 != 1) || (n_mant_rcv - m0 != 1) || (n_norm_start - n0 != 1)) begin
         failures++;
         $display("FAIL normal_pulse_count got=%0d/%0d/%0d exp=1/1/1",
                  n_exp_rcv - e0, n_mant_rcv - m0, n_norm_start - n0);
      end
   endtask

   task automatic test_decode_nar();
      int s0;
      s0 = n_exp_start;
      cyc(); in_valid = 1'b1;
      cyc(); in_valid = 1'b0; dec_done = 1'b1; dec_nar = 1'b1; dec_zero = 1'b1; #1;
      checks++;
      if ({exp_start, mant_start} !== 2'b00) begin
         failures++; $display("FAIL nar_no_start got=%b exp=00", {exp_start, mant_start});
      end
      cyc(); dec_done = 1'b0; dec_nar = 1'b0; dec_zero = 1'b0; #1;
      checks++;
      if ({out_valid, res_nar, res_zero} !== 3'b110) begin
         failures++; $display("FAIL nar_hold got=%b exp=110", {out_valid, res_nar, res_zero});
      end
      release_hold(); #1;
      checks++;
      if ({in_ready, res_nar, n_exp_start - s0 == 0} !== 3'b101) begin
         failures++;
         $display("FAIL nar_release got=%b starts=%0d exp=101 starts=0",
                  {in_ready, res_nar, n_exp_start - s0 == 0}, n_exp_start - s0);
      end
   endtask

   task automatic test_exec_flags();
      // exponent overflow, both done levels in the same cycle
      cyc(); in_valid = 1'b1;
      cyc(); in_valid = 1'b0; dec_done = 1'b1;
      cyc(); dec_done = 1'b0; exp_done = 1'b1; mant_done = 1'b1; exp_nar = 1'b1; #1;
      checks++;
      if ({exp_recieved, mant_recieved, norm_start} !== 3'b110) begin
         failures++;
         $display("FAIL ovf_rcv got=%b exp=110", {exp_recieved, mant_recieved, norm_start});
      end
      cyc(); exp_done = 1'b0; mant_done = 1'b0; exp_nar = 1'b0; #1;
      checks++;
      if ({out_valid, res_nar, res_zero} !== 3'b110) begin
         failures++; $display("FAIL ovf_hold got=%b exp=110", {out_valid, res_nar, res_zero});
      end
      release_hold();
      // exponent underflow, mantissa done before exponent done
      cyc(); in_valid = 1'b1;
      cyc(); in_valid = 1'b0; dec_done = 1'b1;
      cyc(); dec_done = 1'b0; mant_done = 1'b1; #1;
      checks++;
      if ({exp_recieved, mant_recieved} !== 2'b00) begin
         failures++; $display("FAIL unf_wait got=%b exp=00", {exp_recieved, mant_recieved});
      end
      cyc(); mant_done = 1'b0; exp_done = 1'b1; exp_zero = 1'b1; #1;
      checks++;
      if ({exp_recieved, mant_recieved, norm_start} !== 3'b110) begin
         failures++;
         $display("FAIL unf_rcv got=%b exp=110", {exp_recieved, mant_recieved, norm_start});
      end
      cyc(); exp_done = 1'b0; exp_zero = 1'b0; #1;
      checks++;
      if ({out_valid, res_nar, res_zero} !== 3'b101) begin
         failures++; $display("FAIL unf_hold got=%b exp=101", {out_valid, res_nar, res_zero});
      end
      release_hold();
   endtask

   task automatic test_backpressure();
      cyc(); in_valid = 1'b1;
      cyc(); in_valid = 1'b0; dec_done = 1'b1;
      cyc(); dec_done = 1'b0; exp_done = 1'b1; mant_done = 1'b1; #1;
      checks++;
      if (norm_start !== 1'b1) begin
         failures++; $display("FAIL bp_norm_start got=%b exp=1", norm_start);
      end
      cyc(); exp_done = 1'b0; mant_done = 1'b0; norm_done = 1'b1; #1;
      checks++;
      if (out_valid !== 1'b0) begin
         failures++; $display("FAIL bp_latency3 got=%b exp=0", out_valid);
      end
      cyc(); norm_done = 1'b0;
      for (int i = 0; i < 10; i++) begin
         #1;
         checks++;
         if ({out_valid, res_nar, res_zero, in_ready, busy} !== 5'b10001) begin
            failures++;
            $display("FAIL bp_stable cycle=%0d got=%b exp=10001", i,
                     {out_valid, res_nar, res_zero, in_ready, busy});
         end
         cyc();
      end
      release_hold(); #1;
      checks++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
         failures++; $display("FAIL bp_release got=%b exp=100", {in_ready, out_valid, busy});
      end
   endtask

   task automatic test_timeout();
      int r0;
      r0 = n_exp_rcv;
      cyc(); in_valid = 1'b1;
      cyc(); in_valid = 1'b0; dec_done = 1'b1;
      cyc(); dec_done = 1'b0; exp_done = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         checks++;
         if ({out_valid, err, exp_recieved} !== 3'b000) begin
            failures++;
            $display("FAIL to_exec cycle=%0d got=%b exp=000", i, {out_valid, err, exp_recieved});
         end
         cyc();
      end
      #1;
      checks++;
      if ({out_valid, err, res_nar, res_zero} !== 4'b1110) begin
         failures++; $display("FAIL to_hold got=%b exp=1110", {out_valid, err, res_nar, res_zero});
      end
      checks++;
      if (n_exp_rcv != r0) begin
         failures++; $display("FAIL to_no_rcv got=%0d exp=0", n_exp_rcv - r0);
      end
      exp_done = 1'b0;
      release_hold();
      cyc(); in_valid = 1'b1;
      cyc(); in_valid = 1'b0; dec_done = 1'b1;
      cyc(); dec_done = 1'b0; exp_done = 1'b1; mant_done = 1'b1;
      cyc(); exp_done = 1'b0; mant_done = 1'b0; norm_done = 1'b1;
      cyc(); norm_done = 1'b0; #1;
      checks++;
      if ({out_valid, res_nar, err} !== 3'b101) begin
         failures++; $display("FAIL to_next_op got=%b exp=101", {out_valid, res_nar, err});
      end
      release_hold();
   endtask

   task automatic test_reset_exec();
      int r0;
      cyc(); in_valid = 1'b1;
      cyc(); in_valid = 1'b0; dec_done = 1'b1;
      cyc(); dec_done = 1'b0; exp_done = 1'b1; #1;
      r0 = n_exp_rcv + n_mant_rcv;
      checks++;
      if ({busy, err} !== 2'b11) begin
         failures++; $display("FAIL rx_in_exec got=%b exp=11", {busy, err});
      end
      rst_n = 1'b0; #1;
      checks++;
      if ({in_ready, busy, out_valid, err, res_nar, res_zero, exp_recieved, mant_recieved,
           exp_start, mant_start, norm_start, dec_start} !== 12'b100000000000) begin
         failures++;
         $display("FAIL rx_reset got=%b exp=100000000000", {in_ready, busy, out_valid, err,
                  res_nar, res_zero, exp_recieved, mant_recieved, exp_start, mant_start,
                  norm_start, dec_start});
      end
      cyc(); mant_done = 1'b1; #1;
      checks++;
      if ({exp_recieved, mant_recieved} !== 2'b00) begin
         failures++; $display("FAIL rx_no_rcv got=%b exp=00", {exp_recieved, mant_recieved});
      end
      cyc(); exp_done = 1'b0; mant_done = 1'b0; rst_n = 1'b1;
      checks++;
      if (n_exp_rcv + n_mant_rcv != r0) begin
         failures++; $display("FAIL rx_rcv_count got=%0d exp=0", n_exp_rcv + n_mant_rcv - r0);
      end
      // stale exp_done from before reset must not pair with a new mant_done
      cyc(); in_valid = 1'b1;
      cyc(); in_valid = 1'b0; dec_done = 1'b1;
      cyc(); dec_done = 1'b0; mant_done = 1'b1; #1;
      checks++;
      if ({exp_recieved, mant_recieved} !== 2'b00) begin
         failures++; $display("FAIL rx_sticky_clear got=%b exp=00", {exp_recieved, mant_recieved});
      end
      cyc(); mant_done = 1'b0; exp_done = 1'b1; #1;
      checks++;
      if ({exp_recieved, mant_recieved, norm_start} !== 3'b111) begin
         failures++;
         $display("FAIL rx_after_rcv got=%b exp=111", {exp_recieved, mant_recieved, norm_start});
      end
      cyc(); exp_done = 1'b0; norm_done = 1'b1;
      cyc(); norm_done = 1'b0; #1;
      checks++;
      if ({out_valid, res_nar, res_zero, err} !== 4'b1000) begin
         failures++; $display("FAIL rx_after_hold got=%b exp=1000", {out_valid, res_nar, res_zero, err});
      end
      release_hold();
   endtask

   initial begin
      test_reset();
      test_normal();
      test_decode_nar();
      test_exec_flags();
      test_backpressure();
      test_timeout();
      test_reset_exec();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
